regfile_writeback_unit: RTL and testbench
=========================================

// Module: regfile_writeback_unit
// PURPOSE
//  Writer side of the 64-bit register file write port (rd/WriteData/RegWrite).
//  Accepts writeback requests from the ALU and the load unit over valid/ready,
//  arbitrates them and buffers them in a small FIFO. Drains one entry per cycle
//  into the register file and exports a pending-rd scoreboard for hazard detection.
// PARAMETERS
//  XLEN   64  data width of each writeback entry
//  DEPTH  4   FIFO entries; power of two, >=2
//  AW     5   register address width (32 architectural registers)
// PORTS
//  clk        in   1         clock, all state on posedge
//  reset      in   1         synchronous, active-high
//  alu_valid  in   1         ALU writeback request
//  alu_ready  out  1         ALU request accepted this cycle when valid&ready
//  alu_rd     in   AW        ALU destination register
//  alu_data   in   XLEN      ALU result
//  ld_valid   in   1         load-unit writeback request
//  ld_ready   out  1         load request accepted when valid&ready
//  ld_rd      in   AW        load destination register
//  ld_data    in   XLEN      load data
//  wb_hold    in   1         register file write port unavailable; no pop
//  wb_we      out  1         to regfile RegWrite
//  wb_rd      out  AW        to regfile rd
//  wb_data    out  XLEN      to regfile WriteData
//  pending    out  32        bit r = write to r still outstanding
//  count      out  $clog2(DEPTH)+1  FIFO occupancy
//  full/empty out  1         count==DEPTH / count==0
//  rs1,rs2    in   AW        bypass lookup addresses
//  fwd1_hit,fwd2_hit    out 1     bypass match for rs1/rs2
//  fwd1_data,fwd2_data  out XLEN  bypass data for rs1/rs2
// BEHAVIOUR
//  - Reset: pointers/count 0, wb_we=0, wb_rd=0, wb_data=0, pending=0, empty=1,
//    full=0. Reset mid-operation discards all queued entries; no write issued.
//  - Ready: ld_ready = !full; alu_ready = !full & !ld_valid (load has priority).
//    Readies depend on full only; a same-cycle pop does not free a slot for push.
//  - At most one enqueue per cycle. A fired request with rd==0 completes the
//    handshake but is dropped (not enqueued, never written).
//  - Pop: at posedge, if !empty & !wb_hold, head moves into wb_rd/wb_data and
//    wb_we=1 for that one cycle; otherwise wb_we=0 (wb_rd/wb_data hold value).
//  - Latency: request fired at edge N -> wb_we high in cycle after edge N+1
//    (absent hold). Entries written strictly in acceptance order.
//  - Simultaneous push and pop: both take effect; count unchanged.
//  - Pointers wrap modulo DEPTH; count distinguishes full from empty.
//  - pending (combinational): bit r set if any valid FIFO entry has rd==r, or
//    wb_we=1 with wb_rd==r. pending[0] always 0.
// CONFIGURATION
//  REGFILE_WB_BYPASS_EN defined: fwdN_hit=1 when rsN!=0 matches a FIFO entry or
//   the active wb output; fwdN_data = youngest match (newest FIFO entry first,
//   then older entries, then wb output when wb_we=1). Combinational.
//  Not defined: ports remain, fwdN_hit=0, fwdN_data=0; no comparator logic.
// TESTING
//  1 Assert reset 2 cycles mid-traffic -> wb_we=0, empty=1, count=0, pending=0.
//  2 ALU rd=5 data=0xDEAD at edge N -> pending[5]=1 from N; wb_we=1,
//    wb_rd=5, wb_data=0xDEAD after N+1; pending[5]=0 after N+2.
//  3 ld rd=3 and alu rd=4 same cycle -> ld accepted, alu_ready=0; alu accepted
//    next cycle; writes issued rd=3 then rd=4.
//  4 wb_hold=1, push 4 entries -> full=1, ld_ready=alu_ready=0, count=4; release
//    hold -> 4 consecutive wb_we pulses in order, then empty=1.
//  5 ALU rd=0 data=0x55 -> alu_ready=1, count stays 0, no wb_we, pending=0.
//  6 BYPASS_EN, hold=1, push rd=7 data=1 then rd=7 data=2, rs1=7 ->
//    fwd1_hit=1, fwd1_data=2; rs2=0 -> fwd2_hit=0.

Source files
------------

// File: rtl/regfile_writeback_unit.sv
// ---------------------------------------------------------------------------
// regfile_writeback_unit
//
// Writer side of the register file write port. Accepts writeback requests
// from the ALU and the load unit, arbitrates them (load wins), and buffers
// them in a small in-order FIFO. One entry per cycle drains into the register
// file through the registered wb_* outputs. A pending-rd scoreboard tells the
// hazard unit which destinations still have a write outstanding.
//
// Optional feature (macro REGFILE_WB_BYPASS_EN):
//   When defined, rs1/rs2 are looked up against the FIFO contents and the
//   active wb output, and fwdN_hit/fwdN_data return the youngest match.
//   When undefined, fwdN_hit and fwdN_data are tied to zero.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   alu_valid/ready/rd/data   ALU writeback request channel
//   ld_valid/ready/rd/data    load-unit writeback request channel
//   wb_hold               register file port busy; no drain this cycle
//   wb_we/wb_rd/wb_data   register file write port (RegWrite/rd/WriteData)
//   pending               bit r set while a write to r is outstanding
//   count/full/empty      FIFO occupancy and status
//   rs1, rs2              bypass lookup addresses
//   fwd1_hit/fwd1_data, fwd2_hit/fwd2_data   bypass results
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both high. Readies depend only on the registered occupancy, so a slot freed
// by a same-cycle drain is not offered until the following cycle.
// ---------------------------------------------------------------------------
module regfile_writeback_unit #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_rd,
    input  logic [XLEN-1:0]        alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [AW-1:0]          ld_rd,
    input  logic [XLEN-1:0]        ld_data,
    input  logic                   wb_hold,
    output logic                   wb_we,
    output logic [AW-1:0]          wb_rd,
    output logic [XLEN-1:0]        wb_data,
    output logic [(2**AW)-1:0]     pending,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    input  logic [AW-1:0]          rs1,
    input  logic [AW-1:0]          rs2,
    output logic                   fwd1_hit,
    output logic [XLEN-1:0]        fwd1_data,
    output logic                   fwd2_hit,
    output logic [XLEN-1:0]        fwd2_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // FIFO storage; validity is implied by rd_ptr_q/count_q, so no reset.
    logic [AW-1:0]   rd_mem_q   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            wb_we_q;
    logic [AW-1:0]   wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    logic            full_c;
    logic            empty_c;
    logic            ld_fire;
    logic            alu_fire;
    logic            push;
    logic            pop;
    logic [AW-1:0]   push_rd;
    logic [XLEN-1:0] push_data;

    // ------------------------------------------------------------------
    // Arbitration, push/pop decisions and next-state pointers
    // ------------------------------------------------------------------
    always_comb begin
        full_c    = (count_q == CW'(DEPTH));
        empty_c   = (count_q == '0);
        ld_ready  = !full_c;
        alu_ready = !full_c && !ld_valid;
        ld_fire   = ld_valid && !full_c;
        alu_fire  = alu_valid && !full_c && !ld_valid;
        push_rd   = ld_fire ? ld_rd   : alu_rd;
        push_data = ld_fire ? ld_data : alu_data;
        // Writes to x0 complete the handshake but are discarded here.
        push      = (ld_fire || alu_fire) && (push_rd != '0);
        pop       = !empty_c && !wb_hold;

        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state and registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wb_we_q  <= pop;
            // wb_rd/wb_data keep their last value when nothing drains.
            if (pop) begin
                wb_rd_q   <= rd_mem_q[rd_ptr_q];
                wb_data_q <= data_mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            rd_mem_q[wr_ptr_q]   <= push_rd;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign wb_we   = wb_we_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
    assign count   = count_q;
    assign full    = full_c;
    assign empty   = empty_c;

    // ------------------------------------------------------------------
    // Pending scoreboard: live FIFO entries plus the write on the port now.
    // ------------------------------------------------------------------
    always_comb begin
        pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_q) begin
                pending[rd_mem_q[rd_ptr_q + PW'(k)]] = 1'b1;
            end
        end
        if (wb_we_q) begin
            pending[wb_rd_q] = 1'b1;
        end
        pending[0] = 1'b0;
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Scan oldest to newest so the last match seen is the youngest value:
    // wb output first, then FIFO entries from head towards tail.
    function automatic logic [XLEN:0] lookup(input logic [AW-1:0] rs);
        logic            hit;
        logic [XLEN-1:0] data;
        hit  = 1'b0;
        data = '0;
        if (rs != '0) begin
            if (wb_we_q && (wb_rd_q == rs)) begin
                hit  = 1'b1;
                data = wb_data_q;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if ((CW'(k) < count_q) && (rd_mem_q[rd_ptr_q + PW'(k)] == rs)) begin
                    hit  = 1'b1;
                    data = data_mem_q[rd_ptr_q + PW'(k)];
                end
            end
        end
        return {hit, data};
    endfunction

    assign {fwd1_hit, fwd1_data} = lookup(rs1);
    assign {fwd2_hit, fwd2_data} = lookup(rs2);
`else
    logic unused_rs;
    assign unused_rs = ^{rs1, rs2};
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback_unit
//
// Directed bench for regfile_writeback_unit. Every accepted request with a
// nonzero rd is pushed to exp_q as it is driven; every wb_we pulse pops and
// compares. Occupancy, status flags, readies and the pending vector are
// checked each cycle against the queue model.
// ---------------------------------------------------------------------------
module tb_regfile_writeback_unit;
    localparam int XLEN  = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int SW    = AW + XLEN;

    // -------- clock / reset --------
    logic            clk = 1'b0;
    logic            reset;
    always #5 clk = ~clk;

    logic            alu_valid, ld_valid, wb_hold;
    logic            alu_ready, ld_ready;
    logic [AW-1:0]   alu_rd, ld_rd, rs1, rs2;
    logic [XLEN-1:0] alu_data, ld_data;
    logic            wb_we;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     pending;
    logic [2:0]      count;
    logic            full, empty;
    logic            fwd1_hit, fwd2_hit;
    logic [XLEN-1:0] fwd1_data, fwd2_data;

    regfile_writeback_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .wb_hold(wb_hold), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .pending(pending), .count(count), .full(full), .empty(empty),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data)
    );

    // -------- scoreboard --------
    int              n_checks = 0;
    int              n_pass   = 0;
    logic [SW-1:0]   exp_q[$];
    logic            last_we = 1'b0;
    logic [AW-1:0]   last_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] p;
        p = '0;
        foreach (exp_q[i]) p[exp_q[i][SW-1:XLEN]] = 1'b1;
        if (last_we) p[last_rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // One clock cycle with the queue model; inputs must already be driven.
    task automatic cyc();
        logic          exp_full, exp_we, ld_f, alu_f;
        logic [SW-1:0] ent;
        #1;
        if (reset) begin
            @(posedge clk);
            #1;
            exp_q.delete();
            last_we = 1'b0;
        end else begin
            exp_full = (exp_q.size() == DEPTH);
            chk("ld_ready",  64'(ld_ready),  64'(!exp_full));
            chk("alu_ready", 64'(alu_ready), 64'(!exp_full && !ld_valid));
            ld_f   = ld_valid && !exp_full;
            alu_f  = alu_valid && !exp_full && !ld_valid;
            exp_we = (exp_q.size() != 0) && !wb_hold;
            if (ld_f && ld_rd != '0) exp_q.push_back({ld_rd, ld_data});
            else if (alu_f && alu_rd != '0) exp_q.push_back({alu_rd, alu_data});
            @(posedge clk);
            #1;
            chk("wb_we", 64'(wb_we), 64'(exp_we));
            last_we = exp_we;
            if (exp_we) begin
                ent     = exp_q.pop_front();
                last_rd = ent[SW-1:XLEN];
                chk("wb_rd",   64'(wb_rd), 64'(ent[SW-1:XLEN]));
                chk("wb_data", wb_data,    ent[XLEN-1:0]);
            end
            chk("count",   64'(count),   64'(exp_q.size()));
            chk("empty",   64'(empty),   64'(exp_q.size() == 0));
            chk("full",    64'(full),    64'(exp_q.size() == DEPTH));
            chk("pending", 64'(pending), 64'(model_pend()));
        end
    endtask

    // -------- driver tasks --------
    task automatic push_alu(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
        cyc();
        alu_valid = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_wb_we",   64'(wb_we),   64'(0));
        chk("rst_wb_rd",   64'(wb_rd),   64'(0));
        chk("rst_wb_data", wb_data,      64'(0));
        chk("rst_empty",   64'(empty),   64'(1));
        chk("rst_full",    64'(full),    64'(0));
        chk("rst_count",   64'(count),   64'(0));
        chk("rst_pending", 64'(pending), 64'(0));
    endtask

    int pulses;

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
        wb_hold = 1'b0; rs1 = '0; rs2 = '0;
        cyc();
        cyc();
        reset = 1'b0;
        chk_reset_state();

        // ALU write to x5: pending from acceptance, write one cycle later.
        push_alu(5'd5, 64'hDEAD);
        chk("t2_pend5_acc", 64'(pending[5]), 64'(1));
        chk("t2_we_acc",    64'(wb_we),      64'(0));
        cyc();
        chk("t2_we",     64'(wb_we),   64'(1));
        chk("t2_rd",     64'(wb_rd),   64'(5));
        chk("t2_data",   wb_data,      64'hDEAD);
        cyc();
        chk("t2_pend5_done", 64'(pending[5]), 64'(0));

        // Load and ALU in the same cycle: load first, ALU stalled one cycle.
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 64'h3333;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h4444;
        #1;
        chk("t3_ld_ready",  64'(ld_ready),  64'(1));
        chk("t3_alu_ready", 64'(alu_ready), 64'(0));
        cyc();
        ld_valid = 1'b0;
        cyc();
        alu_valid = 1'b0;
        chk("t3_first_rd", 64'(wb_rd), 64'(3));
        cyc();
        chk("t3_second_rd", 64'(wb_rd), 64'(4));
        cyc();

        // Hold the port, fill the FIFO, try to push while full, then drain.
        wb_hold = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push_alu(5'($urandom_range(31, 1)), {$urandom, $urandom});
        end
        chk("t4_full",  64'(full),  64'(1));
        chk("t4_count", 64'(count), 64'(DEPTH));
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 64'h9;
        alu_valid = 1'b0;
        #1;
        chk("t4_ld_ready_full",  64'(ld_ready),  64'(0));
        chk("t4_alu_ready_full", 64'(alu_ready), 64'(0));
        cyc();
        ld_valid = 1'b0;
        wb_hold = 1'b0;
        pulses = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cyc();
            if (wb_we) pulses++;
        end
        chk("t4_pulses", 64'(pulses), 64'(DEPTH));
        chk("t4_empty",  64'(empty),  64'(1));

        // Write to x0: handshake completes, nothing queued or written.
        alu_valid = 1'b1; alu_rd = '0; alu_data = 64'h55;
        #1;
        chk("t5_alu_ready", 64'(alu_ready), 64'(1));
        cyc();
        alu_valid = 1'b0;
        chk("t5_count",   64'(count),   64'(0));
        chk("t5_pending", 64'(pending), 64'(0));
        cyc();
        chk("t5_no_we", 64'(wb_we), 64'(0));

        // Bypass lookup with two writes to x7 queued behind a hold.
        wb_hold = 1'b1;
        push_alu(5'd7, 64'd1);
        push_alu(5'd7, 64'd2);
        rs1 = 5'd7; rs2 = 5'd0;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        chk("t6_fwd1_hit",  64'(fwd1_hit), 64'(1));
        chk("t6_fwd1_data", fwd1_data,     64'd2);
        chk("t6_fwd2_hit",  64'(fwd2_hit), 64'(0));
`else
        chk("t6_fwd1_hit_off",  64'(fwd1_hit), 64'(0));
        chk("t6_fwd1_data_off", fwd1_data,     64'd0);
        chk("t6_fwd2_hit_off",  64'(fwd2_hit), 64'(0));
`endif
        wb_hold = 1'b0;
        repeat (3) cyc();

        // Random mixed traffic, including x0 targets and holds.
        for (int i = 0; i < 60; i++) begin
            ld_valid  = ($urandom_range(0, 3) == 0);
            ld_rd     = 5'($urandom_range(0, 31));
            ld_data   = {$urandom, $urandom};
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = {$urandom, $urandom};
            wb_hold   = ($urandom_range(0, 3) == 0);
            cyc();
        end

        // Reset in the middle of traffic with a backed-up FIFO.
        wb_hold = 1'b1; alu_valid = 1'b1; alu_rd = 5'd12;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        alu_valid = 1'b0; ld_valid = 1'b0; wb_hold = 1'b0;
        chk_reset_state();
        cyc();
        chk("post_rst_no_we", 64'(wb_we), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
